// File: rtl/byte_memory_loader_if.sv
// rtl/byte_memory_loader_if.sv - load stream and CPU read/write bus of the unified memory
// master is the loader/CPU side, slave is the memory.
interface byte_memory_loader_if #(
  parameter int NRD = 4
);
  logic              load_valid;
  logic [7:0]        load_data;
  logic              load_last;
  logic              load_ready;
  logic              RUN;
  logic [31:0]       load_count;
  logic [NRD*32-1:0] rd_addr;
  logic [NRD*32-1:0] rd_data;
  logic [NRD-1:0]    rd_oob;
  logic              wr_en;
  logic [31:0]       wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_be;
  logic              fault;

  modport master (
    output load_valid, load_data, load_last, rd_addr, wr_en, wr_addr, wr_data, wr_be,
    input  load_ready, RUN, load_count, rd_data, rd_oob, fault
  );

  modport slave (
    input  load_valid, load_data, load_last, rd_addr, wr_en, wr_addr, wr_data, wr_be,
    output load_ready, RUN, load_count, rd_data, rd_oob, fault
  );
endinterface

// File: rtl/byte_memory_loader.sv
// rtl/byte_memory_loader.sv - byte-addressed little-endian memory with clear/load/run phases
// Reads are combinational on every port; writes land only once the image is loaded.
module byte_memory_loader #(
  parameter int MEMSIZE   = 768,
  parameter int NRD       = 4,
  parameter int LOAD_BASE = 0
) (
  input  logic              CLOCK,
  input  logic              RESET,
  byte_memory_loader_if.slave bus
);
  localparam int          AW      = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam logic [32:0] MEM_LIM = 33'(MEMSIZE);
  localparam logic [31:0] LAST_PTR = 32'(MEMSIZE - 1);

  typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN} state_t;

  state_t      state;
  logic [31:0] ptr;
  logic [7:0]  mem [MEMSIZE];

  logic [32:0] wa [4];
  logic [3:0]  wr_ok;
  logic [3:0]  wr_bad;
  logic [32:0] ra;

  // Per-byte write address with a carry bit so addresses near 2^32 never wrap into range.
  always_comb begin
    wr_ok  = '0;
    wr_bad = '0;
    for (int i = 0; i < 4; i++) begin
      wa[i]     = {1'b0, bus.wr_addr} + 33'(i);
      wr_ok[i]  = bus.wr_be[i] && (wa[i] < MEM_LIM);
      wr_bad[i] = bus.wr_be[i] && !(wa[i] < MEM_LIM);
    end
  end

  always_comb begin
    ra          = '0;
    bus.rd_data = '0;
    bus.rd_oob  = '0;
    for (int k = 0; k < NRD; k++) begin
      for (int j = 0; j < 4; j++) begin
        ra = {1'b0, bus.rd_addr[32*k +: 32]} + 33'(j);
        if (ra < MEM_LIM)
          bus.rd_data[32*k + 8*j +: 8] = mem[ra[AW-1:0]];
      end
      bus.rd_oob[k] = (({1'b0, bus.rd_addr[32*k +: 32]} + 33'd3) >= MEM_LIM);
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state          <= S_CLEAR;
      ptr            <= '0;
      bus.load_count <= '0;
      bus.fault      <= 1'b0;
      bus.load_ready <= 1'b0;
      bus.RUN        <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          if (ptr == LAST_PTR) begin
            ptr            <= 32'(LOAD_BASE);
            state          <= S_LOAD;
            bus.load_ready <= 1'b1;
          end else begin
            ptr <= ptr + 32'd1;
          end
        end
        S_LOAD: begin
          if (bus.load_valid && bus.load_ready) begin
            ptr            <= ptr + 32'd1;
            bus.load_count <= bus.load_count + 32'd1;
            if (bus.load_last || ptr == LAST_PTR) begin
              state          <= S_RUN;
              bus.load_ready <= 1'b0;
              bus.RUN        <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (bus.wr_en && |wr_bad)
            bus.fault <= 1'b1;
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  // Memory has no reset; the CLEAR sweep zeroes it after every reset instead.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      case (state)
        S_CLEAR: mem[ptr[AW-1:0]] <= 8'h00;
        S_LOAD: begin
          if (bus.load_valid && bus.load_ready)
            mem[ptr[AW-1:0]] <= bus.load_data;
        end
        S_RUN: begin
          if (bus.wr_en) begin
            for (int i = 0; i < 4; i++) begin
              if (wr_ok[i])
                mem[wa[i][AW-1:0]] <= bus.wr_data[8*i +: 8];
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
